// File: rtl/vga_cell_arbiter.sv
// Shares one single-port cell RAM between the fixed-schedule text-mode glyph
// fetcher (always wins) and a one-entry buffered host write port.
module vga_cell_arbiter #(
  parameter int COLS     = 80,
  parameter int ROWS     = 40,
  parameter int CELL_H   = 12,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        host_valid,
  input  logic [11:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic        host_err,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  glyph_code,
  output logic        glyph_valid
);

  localparam int LW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam logic [9:0]    H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_COL0_SLOT = 10'(H_TOTAL - 8);
  localparam logic [9:0]    H_LINE_ADV  = 10'(H_TOTAL - 16);
  localparam logic [9:0]    H_FETCH_END = 10'(H_ACTIVE - 8);
  localparam logic [9:0]    H_CELL_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    V_ACT       = 10'(V_ACTIVE);
  localparam logic [11:0]   CELL_COUNT  = 12'(COLS * ROWS);
  localparam logic [11:0]   ROW_STEP    = 12'(COLS);
  localparam logic [LW-1:0] LIC_LAST    = LW'(CELL_H - 1);

  logic [11:0]   row_base_reg;
  logic [LW-1:0] line_in_cell_reg;
  logic          hold_full_reg;
  logic [11:0]   hold_addr_reg;
  logic [7:0]    hold_data_reg;
  logic          rd_pend_reg;
  logic [7:0]    pending_reg;
  logic          host_err_reg;
  logic [11:0]   mem_addr_reg;
  logic          mem_re_reg;
  logic          mem_we_reg;
  logic [7:0]    mem_wdata_reg;
  logic [7:0]    glyph_code_reg;
  logic          glyph_valid_reg;

  logic          last_h;
  logic          last_v;
  logic [9:0]    v_adv;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          slot_next;
  logic [6:0]    col_next;
  logic [11:0]   fetch_addr;
  logic          drain;
  logic          hold_ok;
  logic          cell_active;

  // Strobes are registered, so the schedule is decoded for the position the
  // counters will hold in the coming cycle.
  always_comb begin
    last_h      = (hpos == H_LAST);
    last_v      = (vpos == V_LAST);
    v_adv       = last_v ? 10'd0 : vpos + 10'd1;
    h_next      = last_h ? 10'd0 : hpos + 10'd1;
    v_next      = last_h ? v_adv : vpos;
    slot_next   = (h_next[2:0] == 3'd0)
                  && ((h_next < H_FETCH_END) || (h_next == H_COL0_SLOT))
                  && ((v_next < V_ACT) || (v_next == V_LAST));
    col_next    = (h_next == H_COL0_SLOT) ? 7'd0 : h_next[9:3] + 7'd1;
    fetch_addr  = row_base_reg + {5'd0, col_next};
    drain       = hold_full_reg && !slot_next;
    hold_ok     = (hold_addr_reg < CELL_COUNT);
    cell_active = last_h ? (v_adv < V_ACT)
                         : ((hpos < H_CELL_END) && (vpos < V_ACT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_base_reg     <= '0;
      line_in_cell_reg <= '0;
      hold_full_reg    <= 1'b0;
      hold_addr_reg    <= '0;
      hold_data_reg    <= '0;
      rd_pend_reg      <= 1'b0;
      pending_reg      <= '0;
      host_err_reg     <= 1'b0;
      mem_addr_reg     <= '0;
      mem_re_reg       <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_wdata_reg    <= '0;
      glyph_code_reg   <= '0;
      glyph_valid_reg  <= 1'b0;
    end else begin
      if (hpos == H_LINE_ADV) begin
        if (v_adv == 10'd0) begin
          line_in_cell_reg <= '0;
          row_base_reg     <= '0;
        end else if (v_adv < V_ACT) begin
          if (line_in_cell_reg == LIC_LAST) begin
            line_in_cell_reg <= '0;
            row_base_reg     <= row_base_reg + ROW_STEP;
          end else begin
            line_in_cell_reg <= line_in_cell_reg + 1'b1;
          end
        end
      end

      mem_re_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      if (slot_next) begin
        mem_re_reg   <= 1'b1;
        mem_addr_reg <= fetch_addr;
      end else if (drain) begin
        if (hold_ok) begin
          mem_we_reg    <= 1'b1;
          mem_addr_reg  <= hold_addr_reg;
          mem_wdata_reg <= hold_data_reg;
        end else begin
          host_err_reg <= 1'b1;
        end
      end

      // Accept and drain are exclusive: a full holding register blocks the host.
      if (hold_full_reg) begin
        if (!slot_next) hold_full_reg <= 1'b0;
      end else if (host_valid) begin
        hold_full_reg <= 1'b1;
        hold_addr_reg <= host_addr;
        hold_data_reg <= host_data;
      end

      rd_pend_reg <= mem_re_reg;
      if (rd_pend_reg) pending_reg <= mem_rdata;

      if (hpos[2:0] == 3'd7) begin
        glyph_code_reg  <= pending_reg;
        glyph_valid_reg <= cell_active;
      end
    end
  end

  assign host_ready  = ~hold_full_reg;
  assign host_err    = host_err_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_re      = mem_re_reg;
  assign mem_we      = mem_we_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign glyph_code  = glyph_code_reg;
  assign glyph_valid = glyph_valid_reg;

endmodule

// File: tb/tb_vga_cell_arbiter.sv
// Directed bench for vga_cell_arbiter: drives its own 800x525 timing counters
// and models the cell RAM (registered read, unwritten cells read as addr[7:0]).
module tb_vga_cell_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        host_valid = 1'b0;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_data = '0;
  logic        host_ready;
  logic        host_err;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  glyph_code;
  logic        glyph_valid;

  int hc = 0;
  int vc = 0;
  int vec_cnt = 0;
  int miss_cnt = 0;
  int overlap_cnt = 0;

  logic [7:0] ram [0:4095];
  bit         ram_wr [0:4095];

  assign hpos = 10'(hc);
  assign vpos = 10'(vc);

  vga_cell_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .host_err(host_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .glyph_code(glyph_code), .glyph_valid(glyph_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
  end

  always @(negedge clk) if (mem_re && mem_we) overlap_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (hc == 799) begin
      hc = 0;
      vc = (vc == 524) ? 0 : vc + 1;
    end else begin
      hc++;
    end
  endtask

  task automatic goto_pos(input int h, input int v);
    hc = h;
    vc = v;
  endtask

  initial begin
    int bad479;
    int bad480v;
    int bad480r;
    int acc_cnt;
    int wr_cnt;
    int cyc;
    int last_acc;
    int bad_gap;
    bit acc;

    // Reset state, frame walk from the last line of the frame
    goto_pos(0, 524);
    reset = 1'b1;
    repeat (3) step();
    chk("rst_glyph", glyph_code, 0);
    chk("rst_valid", glyph_valid, 0);
    chk("rst_ready", host_ready, 1);
    chk("rst_err", host_err, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    while (vc != 14) begin
      step();
      if (vc == 0 && hc == 0) begin
        chk("l0_fetch_re", mem_re, 1);
        chk("l0_fetch_addr", mem_addr, 1);
      end
      if (vc == 10 && hc == 792) chk("l10_col0_addr", mem_addr, 0);
      if (vc == 11 && hc == 792) begin
        chk("l11_col0_re", mem_re, 1);
        chk("l11_col0_addr_rowstep", mem_addr, 80);
      end
      if (vc == 11 && (hc == 0 || hc == 632)) chk($sformatf("l11_glyph_h%0d", hc), glyph_code, hc / 8);
      if (vc == 13 && hc < 640 && hc % 8 == 0) begin
        chk($sformatf("l13_glyph_k%0d", hc / 8), glyph_code, (80 + hc / 8) & 8'hFF);
        chk($sformatf("l13_valid_k%0d", hc / 8), glyph_valid, 1);
      end
      if (vc == 13 && hc == 640) chk("l13_valid_hblank", glyph_valid, 0);
    end

    // Bottom of the active area
    goto_pos(790, 478);
    repeat (10) step();
    bad479 = 0;
    bad480v = 0;
    bad480r = 0;
    repeat (1600) begin
      if (vc == 479 && hc < 640 && hc % 8 == 0 && !glyph_valid) bad479++;
      if (vc == 480 && glyph_valid) bad480v++;
      if (vc == 480 && mem_re) bad480r++;
      step();
    end
    chk("l479_valid_misses", bad479, 0);
    chk("l480_valid_cycles", bad480v, 0);
    chk("l480_fetch_cycles", bad480r, 0);

    // Host write colliding with the fetch slot at hpos=8
    goto_pos(4, 20);
    step();
    step();
    host_valid = 1'b1;
    host_addr  = 12'd100;
    host_data  = 8'h5A;
    step();
    host_valid = 1'b0;
    chk("col_h7_ready", host_ready, 0);
    step();
    chk("col_h8_re", mem_re, 1);
    chk("col_h8_we", mem_we, 0);
    chk("col_h8_ready", host_ready, 0);
    step();
    chk("col_h9_we", mem_we, 1);
    chk("col_h9_re", mem_re, 0);
    chk("col_h9_addr", mem_addr, 100);
    chk("col_h9_wdata", mem_wdata, 8'h5A);
    chk("col_h9_ready", host_ready, 1);
    $display("host write addr=100 data=5a (collision)");

    // Back-to-back host writes during vertical blanking
    goto_pos(200, 490);
    acc_cnt = 0;
    wr_cnt = 0;
    cyc = 0;
    last_acc = -2;
    bad_gap = 0;
    host_valid = 1'b1;
    host_addr  = 12'd200;
    host_data  = 8'hC0;
    while (wr_cnt < 16 && cyc < 100) begin
      acc = host_valid && host_ready;
      step();
      cyc++;
      if (acc) begin
        if (acc_cnt > 0 && cyc - last_acc != 2) bad_gap++;
        last_acc = cyc;
        acc_cnt++;
        if (acc_cnt < 16) begin
          host_addr = 12'(200 + acc_cnt);
          host_data = 8'(8'hC0 + acc_cnt);
        end else begin
          host_valid = 1'b0;
        end
      end
      if (mem_we) begin
        chk($sformatf("b2b_addr_%0d", wr_cnt), mem_addr, 200 + wr_cnt);
        chk($sformatf("b2b_data_%0d", wr_cnt), mem_wdata, 8'hC0 + wr_cnt);
        $display("host write addr=%0d data=%02h", mem_addr, mem_wdata);
        wr_cnt++;
      end
    end
    host_valid = 1'b0;
    chk("b2b_accepts", acc_cnt, 16);
    chk("b2b_writes", wr_cnt, 16);
    chk("b2b_bad_gaps", bad_gap, 0);
    step();
    chk("ram_100", ram[100], 8'h5A);
    chk("ram_200", ram[200], 8'hC0);
    chk("ram_215", ram[215], 8'hCF);

    // Out-of-range address then the last valid cell
    goto_pos(100, 495);
    host_valid = 1'b1;
    host_addr  = 12'd3200;
    host_data  = 8'h11;
    step();
    host_valid = 1'b0;
    chk("oor_ready_low", host_ready, 0);
    chk("oor_err_pre", host_err, 0);
    step();
    chk("oor_we", mem_we, 0);
    chk("oor_err", host_err, 1);
    chk("oor_ready_back", host_ready, 1);
    $display("host write addr=3200 data=11 (discarded)");
    host_valid = 1'b1;
    host_addr  = 12'd3199;
    host_data  = 8'h77;
    step();
    host_valid = 1'b0;
    chk("last_ready_low", host_ready, 0);
    step();
    chk("last_we", mem_we, 1);
    chk("last_addr", mem_addr, 3199);
    chk("last_wdata", mem_wdata, 8'h77);
    chk("last_err_sticky", host_err, 1);
    $display("host write addr=3199 data=77");

    // Reset with a held write and a fetch in flight
    goto_pos(4, 30);
    step();
    step();
    host_valid = 1'b1;
    host_addr  = 12'd300;
    host_data  = 8'h33;
    step();
    host_valid = 1'b0;
    step();
    chk("rmid_h8_re", mem_re, 1);
    chk("rmid_h8_ready", host_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_we", mem_we, 0);
    chk("rmid_re", mem_re, 0);
    chk("rmid_glyph", glyph_code, 0);
    chk("rmid_valid", glyph_valid, 0);
    chk("rmid_ready", host_ready, 1);
    chk("rmid_err", host_err, 0);
    step();
    chk("rmid_no_late_we", mem_we, 0);
    step();
    chk("ram_300_untouched", ram_wr[300], 0);

    chk("re_we_overlap", overlap_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/vga_cell_arbiter.md
VGA_CELL_ARBITER -- requirements
Module: vga_cell_arbiter

Interface
REQ-001 Parameters: COLS, 80, cell columns; ROWS, 40, cell rows; CELL_H, 12, scanlines per cell; H_TOTAL, 800, clocks per line; V_TOTAL, 525, lines per frame; H_ACTIVE, 640; V_ACTIVE, 480.
REQ-002 Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- hpos  in  10  horizontal counter from the hvsync generator.
- vpos  in  10  vertical counter from the hvsync generator.
- host_valid  in  1  host write request.
- host_addr  in  12  cell address, row*COLS+col.
- host_data  in  8  glyph code to write.
- host_ready  out  1  host handshake ready.
- host_err  out  1  sticky out-of-range flag.
- mem_addr  out  12  cell RAM address.
- mem_re  out  1  cell RAM read strobe.
- mem_we  out  1  cell RAM write strobe.
- mem_wdata  out  8  cell RAM write data.
- mem_rdata  in  8  cell RAM read data, valid one cycle after mem_re.
- glyph_code  out  8  glyph index for the cell currently being drawn.
- glyph_valid  out  1  glyph_code belongs to an active cell.

Function
REQ-003 The block SHALL share one single-port cell RAM between a fixed-schedule display fetcher (priority) and a host writer.
REQ-004 Fetch slot: a cycle with hpos[2:0]==0 and (hpos<H_ACTIVE-8 or hpos==H_TOTAL-8), on lines vpos<V_ACTIVE or vpos==V_TOTAL-1.
- In a fetch slot at hpos=8k-8, the fetched column SHALL be k.
- In a fetch slot at hpos=H_TOTAL-8, the fetched column SHALL be 0.
REQ-005 Fetch address SHALL be row_base+col, where row_base is a register. No multiplier or divider SHALL be used.
REQ-006 Line-advance event at hpos==H_TOTAL-16. State SHALL update for the next line N (N = vpos+1, or 0 when vpos==V_TOTAL-1):
- N==0: line_in_cell=0, row_base=0.
- 0<N<V_ACTIVE: line_in_cell+1. On wrap from CELL_H-1 to 0, row_base += COLS.
- Otherwise: hold.
REQ-007 In a fetch slot the block SHALL drive mem_re=1, mem_we=0, mem_addr=fetch address. It SHALL capture mem_rdata the following cycle into a pending register.
REQ-008 At each rising edge where hpos[2:0]==7, pending SHALL transfer to glyph_code. glyph_code is then stable for the 8 pixels of the next cell.
REQ-009 glyph_valid SHALL load with the same edge. It SHALL be 1 iff the cell about to be drawn lies in the active area. This covers hpos==H_TOTAL-1 for col 0, with the next line < V_ACTIVE.
REQ-010 Host accept: host_valid && host_ready. host_ready SHALL equal ~hold_full, with no bypass path.
- On accept, addr/data SHALL load into a one-entry hold register and hold_full SHALL set.
REQ-011 Drain: in any cycle with hold_full=1 that is not a fetch slot, the block SHALL drive mem_we=1, mem_re=0, mem_addr/mem_wdata=hold contents, then clear hold_full.
- Maximum host throughput: one write per 2 cycles.
REQ-012 A held write whose address is >= COLS*ROWS (3200) SHALL be discarded at drain time (mem_we=0) and SHALL set host_err. host_err clears only on reset.
REQ-013 Simultaneous fetch slot and full hold register: the fetch wins and the write SHALL wait. Two fetch slots are never adjacent, so the write always drains within 2 cycles.
REQ-014 mem_re and mem_we SHALL never be high in the same cycle. When idle, both SHALL be 0 and mem_addr/mem_wdata hold their last value.
REQ-015 All outputs SHALL be registered except host_ready, which is the inverse of a register bit.

Reset
REQ-016 While reset=1, all registers SHALL take these values on every clock edge, overriding handshakes and fetches in progress: glyph_code=0, glyph_valid=0, pending=0, hold_full=0 (host_ready=1), host_err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, row_base=0, line_in_cell=0.
REQ-017 After reset deasserts mid-frame, row_base/line_in_cell SHALL remain 0 until the next line-advance event, then follow REQ-006. Correct addresses are guaranteed from the next frame start.

Verification
REQ-018 Frame walk: preload RAM[a]=a[7:0], run one frame from reset at vpos=524 -> at vpos=13, hpos=8k, glyph_code==(80+k)[7:0] for k=0..79, glyph_valid=1.
REQ-019 Row wrap: observe lines 11->12 and 479->480 -> row_base steps 0->80 at the line-advance event before line 12; glyph_valid=0 throughout line 480.
REQ-020 Collision: host_valid with addr=100, data=0x5A asserted so hold fills at hpos=7 (fetch slot at hpos=8) -> hpos=8 cycle mem_re=1, mem_we=0; hpos=9 cycle mem_we=1, mem_addr=100, mem_wdata=0x5A; host_ready low exactly two cycles.
REQ-021 Back-to-back host writes in blanking, 16 requests -> accepted every 2nd cycle, 16 mem_we pulses, addresses in order, no lost data.
REQ-022 Out-of-range: write addr=3200 -> no mem_we, host_err=1 next cycle, host_ready returns to 1; a following write to 3199 succeeds.
REQ-023 Reset mid-operation: assert reset for 1 cycle while hold_full=1 and a fetch is pending -> no mem_we issued, glyph_code=0, glyph_valid=0, host_ready=1 the cycle after reset.
